// File: rtl/midi_msg_parser_if.sv
// Byte-in / message-out bundle for midi_msg_parser.
// master: byte source and message consumer; slave: the parser itself.
interface midi_msg_parser_if;
    logic       rxdv;
    logic [7:0] rxdata;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] msg_b0;
    logic [6:0] msg_b1;
    logic [6:0] msg_b2;
    logic [1:0] msg_len;
    logic       rt_valid;
    logic [7:0] rt_byte;
    logic       drop;

    modport master (
        output rxdv, rxdata, msg_ready,
        input  msg_valid, msg_b0, msg_b1, msg_b2, msg_len, rt_valid, rt_byte, drop
    );

    modport slave (
        input  rxdv, rxdata, msg_ready,
        output msg_valid, msg_b0, msg_b1, msg_b2, msg_len, rt_valid, rt_byte, drop
    );
endinterface

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream to message parser with running status and real-time bypass.
// Define MIDI_PARSER_SYSEX_EN to emit every sysex byte as a one-byte message.
module midi_msg_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 120000
) (
    input logic               clk,
    input logic               rst,
    midi_msg_parser_if.slave  bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2, StSysex} state_e;

    state_e          state_q, state_d;
    logic [7:0]      rs_q, rs_d;
    logic            rs_vld_q, rs_vld_d;
    logic [7:0]      st_q, st_d;
    logic [1:0]      len_q, len_d;
    logic [6:0]      b1_q, b1_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            msg_valid_q, msg_valid_d;
    logic [7:0]      msg_b0_q, msg_b0_d;
    logic [6:0]      msg_b1_q, msg_b1_d, msg_b2_q, msg_b2_d;
    logic [1:0]      msg_len_q, msg_len_d;
    logic            rt_valid_q, rt_valid_d;
    logic [7:0]      rt_byte_q, rt_byte_d;
    logic            drop_q, drop_d;

    logic [7:0]      rx_byte;
    logic            is_rt, timeout, done, load;
    logic [7:0]      done_b0;
    logic [6:0]      done_b1, done_b2;
    logic [1:0]      done_len;
    state_e          after_done;

    assign rx_byte    = bus.rxdata;
    assign is_rt      = bus.rxdv && (rx_byte >= 8'hF8);
    assign timeout    = (cnt_q == CntW'(TIMEOUT_CYCLES)) &&
                        (state_q == StWaitD1 || state_q == StWaitD2);
    // Channel messages keep running status; system common ones do not.
    assign after_done = (st_q < 8'hF0) ? StWaitD1 : StIdle;

    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        rs_vld_d = rs_vld_q;
        st_d     = st_q;
        len_d    = len_q;
        b1_d     = b1_q;
        done     = 1'b0;
        done_b0  = 8'h00;
        done_b1  = 7'h00;
        done_b2  = 7'h00;
        done_len = 2'd0;

        if (bus.rxdv && !is_rt) begin
            if (rx_byte[7]) begin
`ifdef MIDI_PARSER_SYSEX_EN
                if (state_q == StSysex && rx_byte == 8'hF7) begin
                    done     = 1'b1;
                    done_b0  = rx_byte;
                    done_len = 2'd1;
                end
`endif
                state_d = StIdle;
                if (rx_byte < 8'hF0) begin
                    rs_d     = rx_byte;
                    rs_vld_d = 1'b1;
                    st_d     = rx_byte;
                    len_d    = (rx_byte[7:5] == 3'b110) ? 2'd2 : 2'd3;
                    state_d  = StWaitD1;
                end else begin
                    rs_vld_d = 1'b0;
                    unique case (rx_byte)
                        8'hF0: begin
                            state_d = StSysex;
`ifdef MIDI_PARSER_SYSEX_EN
                            done     = 1'b1;
                            done_b0  = rx_byte;
                            done_len = 2'd1;
`endif
                        end
                        8'hF1, 8'hF3: begin
                            st_d    = rx_byte;
                            len_d   = 2'd2;
                            state_d = StWaitD1;
                        end
                        8'hF2: begin
                            st_d    = rx_byte;
                            len_d   = 2'd3;
                            state_d = StWaitD1;
                        end
                        8'hF6: begin
                            done     = 1'b1;
                            done_b0  = rx_byte;
                            done_len = 2'd1;
                        end
                        default: ;
                    endcase
                end
            end else begin
                unique case (state_q)
                    StWaitD1: begin
                        b1_d = rx_byte[6:0];
                        if (len_q == 2'd2) begin
                            done     = 1'b1;
                            done_b0  = st_q;
                            done_b1  = rx_byte[6:0];
                            done_len = 2'd2;
                            state_d  = after_done;
                        end else begin
                            state_d = StWaitD2;
                        end
                    end
                    StWaitD2: begin
                        done     = 1'b1;
                        done_b0  = st_q;
                        done_b1  = b1_q;
                        done_b2  = rx_byte[6:0];
                        done_len = 2'd3;
                        state_d  = after_done;
                    end
                    StSysex: begin
`ifdef MIDI_PARSER_SYSEX_EN
                        done     = 1'b1;
                        done_b0  = rx_byte;
                        done_len = 2'd1;
`endif
                    end
                    default: ;
                endcase
            end
        end else if (!bus.rxdv && timeout) begin
            state_d = rs_vld_q ? StWaitD1 : StIdle;
        end

        if (bus.rxdv) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Single-entry output register; a simultaneous transfer frees the slot.
    always_comb begin
        load        = done && (!msg_valid_q || bus.msg_ready);
        drop_d      = done && !load;
        msg_valid_d = msg_valid_q && !bus.msg_ready;
        msg_b0_d    = msg_b0_q;
        msg_b1_d    = msg_b1_q;
        msg_b2_d    = msg_b2_q;
        msg_len_d   = msg_len_q;
        if (load) begin
            msg_valid_d = 1'b1;
            msg_b0_d    = done_b0;
            msg_b1_d    = done_b1;
            msg_b2_d    = done_b2;
            msg_len_d   = done_len;
        end
        rt_valid_d = is_rt;
        rt_byte_d  = is_rt ? rx_byte : rt_byte_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rs_q        <= 8'h00;
            rs_vld_q    <= 1'b0;
            st_q        <= 8'h00;
            len_q       <= 2'd0;
            b1_q        <= 7'h00;
            cnt_q       <= '0;
            msg_valid_q <= 1'b0;
            msg_b0_q    <= 8'h00;
            msg_b1_q    <= 7'h00;
            msg_b2_q    <= 7'h00;
            msg_len_q   <= 2'd0;
            rt_valid_q  <= 1'b0;
            rt_byte_q   <= 8'h00;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs_q        <= rs_d;
            rs_vld_q    <= rs_vld_d;
            st_q        <= st_d;
            len_q       <= len_d;
            b1_q        <= b1_d;
            cnt_q       <= cnt_d;
            msg_valid_q <= msg_valid_d;
            msg_b0_q    <= msg_b0_d;
            msg_b1_q    <= msg_b1_d;
            msg_b2_q    <= msg_b2_d;
            msg_len_q   <= msg_len_d;
            rt_valid_q  <= rt_valid_d;
            rt_byte_q   <= rt_byte_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.msg_valid = msg_valid_q;
    assign bus.msg_b0    = msg_b0_q;
    assign bus.msg_b1    = msg_b1_q;
    assign bus.msg_b2    = msg_b2_q;
    assign bus.msg_len   = msg_len_q;
    assign bus.rt_valid  = rt_valid_q;
    assign bus.rt_byte   = rt_byte_q;
    assign bus.drop      = drop_q;
endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench for midi_msg_parser; follows MIDI_PARSER_SYSEX_EN if defined.
module tb_midi_msg_parser;
    localparam int unsigned TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    midi_msg_parser_if bus ();

    midi_msg_parser #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_msg(input string tag, input logic [7:0] b0, input logic [6:0] b1,
                           input logic [6:0] b2, input logic [1:0] len);
        chk({tag, ".valid"}, 32'(bus.msg_valid), 32'd1);
        chk({tag, ".b0"},    32'(bus.msg_b0),    32'(b0));
        chk({tag, ".b1"},    32'(bus.msg_b1),    32'(b1));
        chk({tag, ".b2"},    32'(bus.msg_b2),    32'(b2));
        chk({tag, ".len"},   32'(bus.msg_len),   32'(len));
    endtask

    // Present one byte for one cycle; returns at the next falling edge.
    task automatic send(input logic [7:0] b);
        bus.rxdv   = 1'b1;
        bus.rxdata = b;
        @(negedge clk);
        bus.rxdv   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.rxdv      = 1'b0;
        bus.rxdata    = 8'h00;
        bus.msg_ready = 1'b1;
        idle(2);
        chk("rst.msg_valid", 32'(bus.msg_valid), 32'd0);
        chk("rst.b0",        32'(bus.msg_b0),    32'd0);
        chk("rst.b1",        32'(bus.msg_b1),    32'd0);
        chk("rst.b2",        32'(bus.msg_b2),    32'd0);
        chk("rst.len",       32'(bus.msg_len),   32'd0);
        chk("rst.rt_valid",  32'(bus.rt_valid),  32'd0);
        chk("rst.rt_byte",   32'(bus.rt_byte),   32'd0);
        chk("rst.drop",      32'(bus.drop),      32'd0);
        rst = 1'b0;
        idle(1);

        // Running status
        send(8'h90); chk("rs.v0", 32'(bus.msg_valid), 32'd0);
        send(8'h3C); chk("rs.v1", 32'(bus.msg_valid), 32'd0);
        send(8'h64); chk_msg("rs.m1", 8'h90, 7'h3C, 7'h64, 2'd3);
        send(8'h3E); chk("rs.v2", 32'(bus.msg_valid), 32'd0);
        send(8'h00); chk_msg("rs.m2", 8'h90, 7'h3E, 7'h00, 2'd3);
        idle(1);     chk("rs.v3", 32'(bus.msg_valid), 32'd0);

        // Real-time interleave
        send(8'hB0);
        send(8'hF8);
        chk("rt.v1", 32'(bus.rt_valid), 32'd1);
        chk("rt.b1", 32'(bus.rt_byte),  32'hF8);
        send(8'h07); chk("rt.v1off", 32'(bus.rt_valid), 32'd0);
        send(8'hFE);
        chk("rt.v2", 32'(bus.rt_valid), 32'd1);
        chk("rt.b2", 32'(bus.rt_byte),  32'hFE);
        send(8'h7F);
        chk_msg("rt.m", 8'hB0, 7'h07, 7'h7F, 2'd3);
        chk("rt.v2off", 32'(bus.rt_valid), 32'd0);
        idle(1);

        // Back-pressure
        bus.msg_ready = 1'b0;
        send(8'hC1);
        send(8'h05); chk_msg("bp.m1", 8'hC1, 7'h05, 7'h00, 2'd2);
        send(8'hC1); chk("bp.drop0", 32'(bus.drop), 32'd0);
        send(8'h06);
        chk("bp.drop1", 32'(bus.drop), 32'd1);
        chk_msg("bp.held", 8'hC1, 7'h05, 7'h00, 2'd2);
        idle(1);     chk("bp.drop2", 32'(bus.drop), 32'd0);
        bus.msg_ready = 1'b1;
        chk_msg("bp.out", 8'hC1, 7'h05, 7'h00, 2'd2);
        idle(1);     chk("bp.fall", 32'(bus.msg_valid), 32'd0);

        // Timeout discards the stale first data byte
        send(8'h80);
        send(8'h40);
        idle(TO + 1);
        send(8'h41); chk("to.v0", 32'(bus.msg_valid), 32'd0);
        send(8'h00); chk_msg("to.m", 8'h80, 7'h41, 7'h00, 2'd3);
        idle(1);

        // Tune request is a complete one-byte message
        send(8'hF6); chk_msg("f6.m", 8'hF6, 7'h00, 7'h00, 2'd1);
        send(8'h12); chk("f6.idle_data", 32'(bus.msg_valid), 32'd0);

        // Sysex
`ifdef MIDI_PARSER_SYSEX_EN
        send(8'hF0); chk_msg("sx.f0", 8'hF0, 7'h00, 7'h00, 2'd1);
        send(8'h43); chk_msg("sx.43", 8'h43, 7'h00, 7'h00, 2'd1);
        send(8'h12); chk_msg("sx.12", 8'h12, 7'h00, 7'h00, 2'd1);
        send(8'hF7); chk_msg("sx.f7", 8'hF7, 7'h00, 7'h00, 2'd1);
`else
        send(8'hF0); chk("sx.f0", 32'(bus.msg_valid), 32'd0);
        send(8'h43); chk("sx.43", 32'(bus.msg_valid), 32'd0);
        send(8'h12); chk("sx.12", 32'(bus.msg_valid), 32'd0);
        send(8'hF7); chk("sx.f7", 32'(bus.msg_valid), 32'd0);
`endif
        send(8'h45); chk("sx.45", 32'(bus.msg_valid), 32'd0);
        idle(1);

        // Reset mid-message
        send(8'h90);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rm.v0", 32'(bus.msg_valid), 32'd0);
        send(8'h3C);
        send(8'h64);
        chk("rm.v1",   32'(bus.msg_valid), 32'd0);
        chk("rm.drop", 32'(bus.drop),      32'd0);
        idle(1);
        chk("rm.v2", 32'(bus.msg_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
